// File: rtl/ibufgds_diff_clk_buf_pkg.sv
// ----------------------------------------------------------------------------
// ibufgds_diff_clk_buf_pkg
// Shared defaults for the differential clock buffer and its health monitor.
//   DEF_WINDOW    : monitor window length in reference-clock cycles
//   DEF_CNT_W     : width of the reported edge count
//   DEF_MIN_EDGES : rising edges per window needed to call the clock present
//   WARMUP_W      : depth of the post-reset warm-up shift register
// ----------------------------------------------------------------------------
package ibufgds_diff_clk_buf_pkg;

  localparam int DEF_WINDOW    = 100;
  localparam int DEF_CNT_W     = 16;
  localparam int DEF_MIN_EDGES = 2;

  // Two synchroniser stages plus one edge-detect stage must fill with real
  // samples before their outputs are trusted.
  localparam int WARMUP_W      = 3;

endpackage

// File: rtl/ibufgds_diff_clk_buf_sync2.sv
// ----------------------------------------------------------------------------
// ibufgds_diff_clk_buf_sync2
// Two-flop synchroniser into the clk domain, async active-low reset to 0.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset
//   d     : asynchronous input
//   q     : synchronised output (two clk cycles of latency)
// ----------------------------------------------------------------------------
module ibufgds_diff_clk_buf_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ibufgds_diff_clk_buf.sv
// ----------------------------------------------------------------------------
// ibufgds_diff_clk_buf
// Differential clock input buffer with a clock-health monitor.
//   clk         : monitor reference clock (free-running, >= 3x O frequency)
//   rst_n       : async active-low reset, monitor only (buffer unaffected)
//   I / IB      : differential true / complement inputs
//   clr_err     : synchronous clear of diff_err (a same-cycle set wins)
//   O           : buffered single-ended clock, combinational
//   edge_count  : rising edges of O in the last completed window (saturating)
//   count_valid : one-cycle pulse when edge_count updates
//   clk_present : last window saw at least MIN_EDGES rising edges
//   diff_err    : sticky flag, I==IB seen for two consecutive clk cycles
// ----------------------------------------------------------------------------
module ibufgds_diff_clk_buf
  import ibufgds_diff_clk_buf_pkg::*;
#(
  parameter int WINDOW    = DEF_WINDOW,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int MIN_EDGES = DEF_MIN_EDGES,
  parameter int DIFF_TERM = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             I,
  input  logic             IB,
  input  logic             clr_err,
  output logic             O,
  output logic [CNT_W-1:0] edge_count,
  output logic             count_valid,
  output logic             clk_present,
  output logic             diff_err
);

  localparam int               WIN_W    = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Termination is a placement attribute of the pad; nothing to build here.
  if (DIFF_TERM != 0) begin : g_diff_term
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             inc);
    if (inc && (v != CNT_MAX)) return v + CNT_W'(1);
    return v;
  endfunction

  // --------------------------------------------------------------------------
  // Buffer: a valid pair passes I straight through; an invalid pair (I==IB)
  // keeps the last valid level. X/Z on an input makes the select unknown, so
  // the mux yields X in simulation.
  // --------------------------------------------------------------------------
  logic o_hold;

  always_latch begin
    if (I ^ IB) o_hold <= I;
  end

  assign O = (I ^ IB) ? I : o_hold;

  // --------------------------------------------------------------------------
  // Stage 0/1: synchronise O, I, IB into the clk domain
  // --------------------------------------------------------------------------
  logic o_s, i_s, ib_s;

  ibufgds_diff_clk_buf_sync2 u_sync_o  (.clk(clk), .rst_n(rst_n), .d(O),  .q(o_s));
  ibufgds_diff_clk_buf_sync2 u_sync_i  (.clk(clk), .rst_n(rst_n), .d(I),  .q(i_s));
  ibufgds_diff_clk_buf_sync2 u_sync_ib (.clk(clk), .rst_n(rst_n), .d(IB), .q(ib_s));

  // --------------------------------------------------------------------------
  // Stage 2: edge detect, window count, differential check
  // --------------------------------------------------------------------------
  // The synchronisers and o_prev come out of reset holding 0, not real
  // samples. warm[1] marks synchronised values as real, warm[2] additionally
  // covers o_prev; without it a static-high O or a reset-valued 0/0 pair
  // would look like an edge or an invalid pair just after reset.
  logic [WARMUP_W-1:0] warm;
  logic                o_prev;
  logic                eq_prev;
  logic [WIN_W-1:0]    win_cnt;
  logic [CNT_W-1:0]    run_cnt;
  logic                rise;
  logic                eq_now;
  logic [CNT_W-1:0]    run_next;
  logic [31:0]         run_ext;

  assign rise     = warm[2] & o_s & ~o_prev;
  assign eq_now   = warm[1] & (i_s == ib_s);
  assign run_next = sat_inc(run_cnt, rise);
  assign run_ext  = 32'(run_next);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm        <= '0;
      o_prev      <= 1'b0;
      eq_prev     <= 1'b0;
      win_cnt     <= '0;
      run_cnt     <= '0;
      edge_count  <= '0;
      count_valid <= 1'b0;
      clk_present <= 1'b0;
      diff_err    <= 1'b0;
    end else begin
      warm    <= {warm[WARMUP_W-2:0], 1'b1};
      o_prev  <= o_s;
      eq_prev <= eq_now;

      // An edge detected on the terminal cycle still belongs to this window.
      if (win_cnt == WIN_LAST) begin
        win_cnt     <= '0;
        run_cnt     <= '0;
        edge_count  <= run_next;
        count_valid <= 1'b1;
        clk_present <= (run_ext >= 32'(MIN_EDGES));
      end else begin
        win_cnt     <= win_cnt + WIN_W'(1);
        run_cnt     <= run_next;
        count_valid <= 1'b0;
      end

      if (eq_now && eq_prev) diff_err <= 1'b1;
      else if (clr_err)      diff_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ibufgds_diff_clk_buf.sv
// ----------------------------------------------------------------------------
// tb_ibufgds_diff_clk_buf
// Drives the differential pair on the falling edge of clk and compares both
// a default instance and a CNT_W=4 instance against a sample-based model.
// ----------------------------------------------------------------------------
module tb_ibufgds_diff_clk_buf;

  localparam int WIN   = 100;
  localparam int MIN_E = 2;
  localparam int NMAX  = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_in = 1'b0;
  logic        ib_in = 1'b1;
  logic        clr_err = 1'b0;

  logic        o, o4;
  logic [15:0] edge_count;
  logic [3:0]  edge_count4;
  logic        count_valid, count_valid4;
  logic        clk_present, clk_present4;
  logic        diff_err, diff_err4;

  ibufgds_diff_clk_buf #(.WINDOW(WIN), .CNT_W(16), .MIN_EDGES(MIN_E), .DIFF_TERM(0)) dut (
    .clk(clk), .rst_n(rst_n), .I(i_in), .IB(ib_in), .clr_err(clr_err),
    .O(o), .edge_count(edge_count), .count_valid(count_valid),
    .clk_present(clk_present), .diff_err(diff_err)
  );

  ibufgds_diff_clk_buf #(.WINDOW(WIN), .CNT_W(4), .MIN_EDGES(MIN_E), .DIFF_TERM(1)) dut4 (
    .clk(clk), .rst_n(rst_n), .I(i_in), .IB(ib_in), .clr_err(clr_err),
    .O(o4), .edge_count(edge_count4), .count_valid(count_valid4),
    .clk_present(clk_present4), .diff_err(diff_err4)
  );

  always #5 clk = ~clk;

  // Reference model: per posedge k (counted from reset release) it records
  // the pair as sampled there; an O rise between samples j-1 and j is seen
  // two sync stages plus one detect stage later, i.e. at posedge j+2, and an
  // invalid pair at samples j-1, j sets diff_err at posedge j+2.
  int  k;
  bit  o_smp   [NMAX];
  bit  eq_smp  [NMAX];
  bit  clr_smp [NMAX];
  bit  rise_at [NMAX];
  bit  m_o;
  bit  m_cv, m_cp, m_cp4, m_de;
  int  m_ec, m_ec4;
  int  n_checks, n_fail;
  bit  lvl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (k=%0d)", tag, obs, exp, k);
    end
  endtask

  task automatic model_reset();
    k     = 0;
    m_cv  = 0; m_cp = 0; m_cp4 = 0; m_de = 0;
    m_ec  = 0; m_ec4 = 0;
  endtask

  // Drive the pair for the next posedge; O must follow immediately.
  task automatic drive(input bit iv, input bit ibv, input bit cv);
    i_in    = iv;
    ib_in   = ibv;
    clr_err = cv;
    if (iv != ibv) m_o = iv;
    #1;
    chk("O", o, m_o);
    chk("O_cnt4", o4, m_o);
  endtask

  // One clk period: sample at posedge, update the model, compare at negedge.
  task automatic cycle();
    int cnt;
    @(posedge clk);
    if (rst_n) begin
      k++;
      o_smp[k]   = m_o;
      eq_smp[k]  = (i_in == ib_in);
      clr_smp[k] = clr_err;
      rise_at[k] = 1'b0;
      if (k >= 4) rise_at[k] = o_smp[k-2] && !o_smp[k-3];
      if (k % WIN == 0) begin
        cnt = 0;
        for (int j = k - WIN + 1; j <= k; j++) cnt += int'(rise_at[j]);
        m_ec  = (cnt > 65535) ? 65535 : cnt;
        m_ec4 = (cnt > 15) ? 15 : cnt;
        m_cp  = (m_ec >= MIN_E);
        m_cp4 = (m_ec4 >= MIN_E);
        m_cv  = 1;
      end else begin
        m_cv  = 0;
      end
      if (k >= 4 && eq_smp[k-2] && eq_smp[k-3]) m_de = 1;
      else if (clr_smp[k])                      m_de = 0;
    end
    @(negedge clk);
    chk("count_valid",  count_valid,  m_cv);
    chk("edge_count",   edge_count,   m_ec);
    chk("clk_present",  clk_present,  m_cp);
    chk("diff_err",     diff_err,     m_de);
    chk("count_valid4", count_valid4, m_cv);
    chk("edge_count4",  edge_count4,  m_ec4);
    chk("clk_present4", clk_present4, m_cp4);
    chk("diff_err4",    diff_err4,    m_de);
  endtask

  initial begin
    bit iv, ibv, cv;
    n_checks = 0;
    n_fail   = 0;
    m_o      = 0;
    model_reset();

    // Reset held: every monitor output at 0
    repeat (3) cycle();
    chk("rst_edge_count", edge_count, 0);
    chk("rst_diff_err", diff_err, 0);

    // Toggle I every 2 clk cycles (20 ns): rises land on samples 2, 6, 10...
    drive(1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
    while (k < 200) begin
      iv = bit'(((k + 1) >> 1) & 1);
      drive(iv, !iv, 1'b0);
      cycle();
      if (k == 99)  chk("first_cv_early", count_valid, 0);
      if (k == 100) begin
        chk("first_cv", count_valid, 1);
        chk("first_edge_count", edge_count, 25);
        chk("first_present", clk_present, 1);
        chk("first_diff_err", diff_err, 0);
      end
    end

    // Static pair I=1/IB=0, briefly 0/1 at the end; window 4 has no rises
    while (k < 400) begin
      iv = (k + 1 <= 394);
      drive(iv, !iv, 1'b0);
      cycle();
      if (k == 390) chk("static_O", o, 1);
      if (k == 400) begin
        chk("static_cv", count_valid, 1);
        chk("static_edge_count", edge_count, 0);
        chk("static_present", clk_present, 0);
      end
    end

    // I=IB=1 for 3 cycles: O holds 0, diff_err sets and stays; clr at 410
    while (k < 415) begin
      if (k + 1 >= 401 && k + 1 <= 403) drive(1'b1, 1'b1, 1'b0);
      else drive(1'b0, 1'b1, (k + 1 == 410));
      cycle();
      if (k == 402) chk("hold_O", o, 0);
      if (k == 406) chk("err_set", diff_err, 1);
      if (k == 409) chk("err_sticky", diff_err, 1);
      if (k == 410) chk("err_cleared", diff_err, 0);
    end

    // I=IB for a single cycle: no error
    while (k < 430) begin
      if (k + 1 == 420) drive(1'b1, 1'b1, 1'b0);
      else drive(1'b1, 1'b0, 1'b0);
      cycle();
      if (k == 425) chk("single_eq_no_err", diff_err, 0);
    end

    // Random phase: slow random level changes, occasional invalid pairs and clears
    lvl = 1'b1;
    while (k < 850) begin
      if ($urandom_range(0, 2) == 0) lvl = !lvl;
      if ($urandom_range(0, 15) == 0) begin
        iv  = bit'($urandom_range(0, 1));
        ibv = iv;
      end else begin
        iv  = lvl;
        ibv = !lvl;
      end
      cv = ($urandom_range(0, 19) == 0);
      drive(iv, ibv, cv);
      cycle();
    end

    // Reset asserted mid-window (cycle 50): outputs clear at once
    clr_err = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk("midrst_edge_count", edge_count, 0);
    chk("midrst_cv", count_valid, 0);
    chk("midrst_present", clk_present, 0);
    chk("midrst_diff_err", diff_err, 0);
    model_reset();
    repeat (3) cycle();

    // After release: first count_valid exactly WINDOW cycles later
    drive(1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
    while (k < 100) begin
      iv = bit'(((k + 1) >> 1) & 1);
      drive(iv, !iv, 1'b0);
      cycle();
      if (k == 99)  chk("post_rst_cv_early", count_valid, 0);
      if (k == 100) begin
        chk("post_rst_cv", count_valid, 1);
        chk("post_rst_edge_count", edge_count, 25);
      end
    end

    // Fast toggling, period 5 clk: 20 edges/window, 4-bit count saturates
    while (k < 300) begin
      iv = ((k + 1) % 5) < 2;
      drive(iv, !iv, 1'b0);
      cycle();
      if (k == 300) begin
        chk("fast_edge_count", edge_count, 20);
        chk("sat_edge_count4", edge_count4, 15);
        chk("sat_present4", clk_present4, 1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ibufgds_diff_clk_buf.md
# ibufgds_diff_clk_buf

Differential clock input buffer with an integrated clock-health monitor. It converts the board oscillator pair (true/complement) into one single-ended clock `O` for the clock-divider tree. A reference-clock-domain monitor counts output edges per window, reports clock presence, and flags invalid differential states. The buffer path is purely combinational; only the monitor is clocked and reset.

## Interface
Parameters:
- `WINDOW` — 100 — measurement window length in `clk` cycles (≥ 2).
- `CNT_W` — 16 — width of `edge_count`.
- `MIN_EDGES` — 2 — minimum rising edges per window for `clk_present`.
- `DIFF_TERM` — 0 — attribute only; no functional effect.

Ports (one clock `clk`; reset `rst_n` is asynchronous and active-low):
- `clk` in 1 — monitor reference clock (free-running, ≥ 3× frequency of `O`).
- `rst_n` in 1 — async active-low reset of monitor logic only.
- `I` in 1 — differential true input.
- `IB` in 1 — differential complement input.
- `clr_err` in 1 — synchronous clear of `diff_err`.
- `O` out 1 — buffered single-ended clock.
- `edge_count` out CNT_W — rising edges of `O` in the last completed window.
- `count_valid` out 1 — one-cycle pulse when `edge_count` updates.
- `clk_present` out 1 — last window had ≥ MIN_EDGES edges.
- `diff_err` out 1 — sticky invalid-differential flag.

## Operation
- Buffer: I=1,IB=0 → O=1; I=0,IB=1 → O=0; I==IB → O holds last valid value; X/Z on either input → O=X (simulation).
- `O` is independent of `rst_n` and `clk`; zero functional delay.
- Monitor synchronises `O`, `I`, `IB` into `clk` domain with two-flop synchronisers.
- Rising-edge detect on synchronised `O` (registered previous value).
- Window counter runs 0..WINDOW-1, wraps. Running edge counter increments per detected edge, saturates at 2^CNT_W−1.
- At window terminal count: `edge_count` ← running count including an edge detected that same cycle; `count_valid` pulses; `clk_present` ← (that count ≥ MIN_EDGES); running count restarts at 0.
- `diff_err` sets when synchronised I==IB for 2 consecutive `clk` cycles; stays set until `clr_err` or reset. Simultaneous set condition and `clr_err`: set wins.

## Timing
- Reset values: `edge_count`=0, `count_valid`=0, `clk_present`=0, `diff_err`=0, window and running counters 0, synchroniser flops 0.
- Edge on `O` → counted 3 `clk` cycles later (2 sync + 1 detect).
- First `count_valid` at cycle WINDOW after reset release; then every WINDOW cycles.
- Reset asserted mid-window: all monitor state clears immediately; partial window discarded.
- `O` stopping: `clk_present` drops at the end of the first window with < MIN_EDGES edges.
- `clr_err` effective next cycle.

## Structure
- Shared package: default `WINDOW`, `CNT_W`, `MIN_EDGES`.
- Sub-module `sync2`: two-flop synchroniser with async active-low reset, instantiated three times.
- Top-level: combinational buffer plus monitor logic.

## Test plan
- Reset, `clk` 10 ns, I toggling every 20 ns (IB = ~I), WINDOW=100 → `count_valid` at cycle 100, `edge_count`=25, `clk_present`=1, `diff_err`=0.
- Static pair (I=1, IB=0) → O=1 constant, `edge_count`=0, `clk_present`=0 after first window.
- I=IB=1 held for 3 `clk` cycles → O holds last value, `diff_err`=1 and stays 1; pulse `clr_err` → 0 next cycle.
- I=IB for exactly 1 `clk` cycle → `diff_err` remains 0.
- Assert `rst_n` at cycle 50 of a window → all outputs 0 immediately; next `count_valid` 100 cycles after release.
- CNT_W=4, fast toggling (20 edges/window) → `edge_count` saturates at 15.
